// File: rtl/vending_pkg.sv
// Shared types and constants for the multi-product vending controller.
// Credit is counted in 0.5 TL units throughout.
package vending_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_CHANGE  = 2'd3
    } state_e;

    // Coin denominations expressed in credit units.
    localparam logic [1:0] HALF = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

    // Default price table: slot 0 = 5 TL, slot 1 = 2 TL, slot 2 = 1.5 TL.
    localparam logic [17:0] DEFAULT_PRICES = {6'd3, 6'd4, 6'd10};

    // Credit units carried by one coin of the given denomination.
    function automatic logic [1:0] coin_units(input logic full);
        logic [1:0] units;
        if (full) begin
            units = FULL;
        end else begin
            units = HALF;
        end
        return units;
    endfunction

endpackage

// File: rtl/vending_motor_timer.sv
// Down-counter that times the VEND motor window and the change-return
// half-periods. A load restarts the count; done is high during the last
// counted cycle so the controller can leave the phase on that edge.
module vending_motor_timer
    import vending_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_r;

    // Load on request, otherwise count down and rest at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == W'(1));

endmodule

// File: rtl/vending_multi.sv
// Multi-product vending controller: coin collection, price check,
// timed product motor and optional change return.
// Build option: define VENDING_CHANGE_EN to enable change return after a
// vend and refund on cancel; without it leftover credit stays in COLLECT.
module vending_multi
    import vending_pkg::*;
#(
    parameter int                              NUM_PRODUCTS = 3,
    parameter int                              CREDIT_W     = 6,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES      = DEFAULT_PRICES,
    parameter int                              MOTOR_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    coin_valid,
    input  logic                    coin_full,
    input  logic                    cancel,
    input  logic [NUM_PRODUCTS-1:0] select,
    output logic [NUM_PRODUCTS-1:0] motor,
    output logic                    change_motor,
    output logic                    coin_reject,
    output logic [CREDIT_W-1:0]     credit,
    output logic                    busy
);

    localparam int          TW         = $clog2(MOTOR_CYCLES + 3);
    localparam logic [TW-1:0] MOTOR_LOAD = TW'(MOTOR_CYCLES);
`ifdef VENDING_CHANGE_EN
    // Two-cycle period: first cycle change_motor high, second cycle low.
    localparam logic [TW-1:0] CHG_LOAD   = TW'(2);
`endif

    state_e                  state_r, state_nx_s;
    logic [CREDIT_W-1:0]     credit_r, credit_nx_s;
    logic [NUM_PRODUCTS-1:0] motor_r, motor_nx_s;
    logic [NUM_PRODUCTS-1:0] vend_oh_r, vend_oh_nx_s;
    logic                    change_r, change_nx_s;
    logic                    reject_r, reject_nx_s;
    logic                    busy_r, busy_nx_s;

    logic                    sel_hit_s;
    logic [NUM_PRODUCTS-1:0] sel_oh_s;
    logic [CREDIT_W-1:0]     sel_price_s;
    logic [CREDIT_W:0]       coin_sum_s;
    logic                    coin_ok_s;
    logic                    tmr_load_s;
    logic [TW-1:0]           tmr_val_s;
    logic                    tmr_done_s;

`ifndef VENDING_CHANGE_EN
    // Refund requests have no effect when change return is not built in.
    logic unused_cancel_s;
    assign unused_cancel_s = cancel;
`endif

    vending_motor_timer #(.W(TW)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .done     (tmr_done_s)
    );

    // Lowest-index priority pick of the requested slot and its price.
    always_comb begin
        sel_hit_s   = 1'b0;
        sel_oh_s    = '0;
        sel_price_s = '0;
        for (int i = NUM_PRODUCTS - 1; i >= 0; i--) begin
            if (select[i]) begin
                sel_hit_s   = 1'b1;
                sel_oh_s    = NUM_PRODUCTS'(1) << i;
                sel_price_s = PRICES[i*CREDIT_W +: CREDIT_W];
            end else begin
                sel_hit_s   = sel_hit_s;
            end
        end
    end

    // Coin acceptance: only while collecting and only if credit cannot wrap.
    always_comb begin
        coin_sum_s = {1'b0, credit_r} + {{(CREDIT_W-1){1'b0}}, coin_units(coin_full)};
        coin_ok_s  = coin_valid
                   && ((state_r == ST_IDLE) || (state_r == ST_COLLECT))
                   && !coin_sum_s[CREDIT_W];
    end

    // Next-state, next-credit and next-output computation.
    always_comb begin
        state_nx_s   = state_r;
        credit_nx_s  = credit_r;
        motor_nx_s   = '0;
        vend_oh_nx_s = vend_oh_r;
        change_nx_s  = 1'b0;
        reject_nx_s  = coin_valid && !coin_ok_s;
        tmr_load_s   = 1'b0;
        tmr_val_s    = '0;

        case (state_r)
            ST_IDLE, ST_COLLECT: begin
                if (coin_ok_s) begin
                    credit_nx_s = coin_sum_s[CREDIT_W-1:0];
                    state_nx_s  = ST_COLLECT;
                end else if (sel_hit_s && (credit_r >= sel_price_s)) begin
                    credit_nx_s  = credit_r - sel_price_s;
                    state_nx_s   = ST_VEND;
                    motor_nx_s   = sel_oh_s;
                    vend_oh_nx_s = sel_oh_s;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = MOTOR_LOAD;
`ifdef VENDING_CHANGE_EN
                end else if (cancel && (state_r == ST_COLLECT)) begin
                    state_nx_s  = ST_CHANGE;
                    change_nx_s = 1'b1;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = CHG_LOAD;
`endif
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_VEND: begin
                if (tmr_done_s) begin
                    if (credit_r != '0) begin
`ifdef VENDING_CHANGE_EN
                        state_nx_s  = ST_CHANGE;
                        change_nx_s = 1'b1;
                        tmr_load_s  = 1'b1;
                        tmr_val_s   = CHG_LOAD;
`else
                        state_nx_s  = ST_COLLECT;
`endif
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    motor_nx_s = vend_oh_r;
                end
            end
            ST_CHANGE: begin
`ifdef VENDING_CHANGE_EN
                if (tmr_done_s) begin
                    // Low half-period over: start the next pulse.
                    change_nx_s = 1'b1;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = CHG_LOAD;
                end else if (credit_r <= CREDIT_W'(1)) begin
                    // Last unit returned in this high cycle.
                    credit_nx_s = '0;
                    state_nx_s  = ST_IDLE;
                end else begin
                    credit_nx_s = credit_r - CREDIT_W'(1);
                end
`else
                state_nx_s = ST_IDLE;
`endif
            end
            default: begin
                state_nx_s  = ST_IDLE;
                credit_nx_s = '0;
            end
        endcase

        busy_nx_s = (state_nx_s == ST_VEND) || (state_nx_s == ST_CHANGE);
    end

    // State, credit and registered output update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            credit_r  <= '0;
            motor_r   <= '0;
            vend_oh_r <= '0;
            change_r  <= 1'b0;
            reject_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            credit_r  <= credit_nx_s;
            motor_r   <= motor_nx_s;
            vend_oh_r <= vend_oh_nx_s;
            change_r  <= change_nx_s;
            reject_r  <= reject_nx_s;
            busy_r    <= busy_nx_s;
        end
    end

    assign motor        = motor_r;
    assign change_motor = change_r;
    assign coin_reject  = reject_r;
    assign credit       = credit_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_vending_multi.sv
// Directed self-checking bench for vending_multi (default parameters).
// Expectations follow the VENDING_CHANGE_EN setting of the build.
module tb_vending_multi;

    logic       clock = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic       coin_full;
    logic       cancel;
    logic [2:0] select;
    logic [2:0] motor;
    logic       change_motor;
    logic       coin_reject;
    logic [5:0] credit;
    logic       busy;

    int checks = 0;
    int errors = 0;

    vending_multi dut (
        .clock        (clock),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_full    (coin_full),
        .cancel       (cancel),
        .select       (select),
        .motor        (motor),
        .change_motor (change_motor),
        .coin_reject  (coin_reject),
        .credit       (credit),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [5:0] c, input logic [2:0] m,
                              input logic chg, input logic rej, input logic bsy);
        chk({tag, ".credit"}, 32'(credit), 32'(c));
        chk({tag, ".motor"},  32'(motor),  32'(m));
        chk({tag, ".change"}, 32'(change_motor), 32'(chg));
        chk({tag, ".reject"}, 32'(coin_reject), 32'(rej));
        chk({tag, ".busy"},   32'(busy), 32'(bsy));
    endtask

    task automatic coins(input int n, input logic full);
        coin_full  = full;
        coin_valid = 1'b1;
        repeat (n) step();
        coin_valid = 1'b0;
        coin_full  = 1'b0;
    endtask

    // Reset with every other input active: reset must win.
    task automatic do_reset(input string tag);
        reset      = 1'b1;
        coin_valid = 1'b1;
        coin_full  = 1'b1;
        select     = 3'b111;
        cancel     = 1'b1;
        step();
        step();
        expect_out(tag, 6'd0, 3'b000, 1'b0, 1'b0, 1'b0);
        reset      = 1'b0;
        coin_valid = 1'b0;
        coin_full  = 1'b0;
        select     = 3'b000;
        cancel     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; coin_valid = 1'b0; coin_full = 1'b0; cancel = 1'b0; select = 3'b000;
        do_reset("rst0");

        // Five 1 TL coins, then product 0 at exactly its price.
        coins(1, 1'b1);
        expect_out("coin1", 6'd2, 3'b000, 1'b0, 1'b0, 1'b0);
        coins(4, 1'b1);
        expect_out("coin5", 6'd10, 3'b000, 1'b0, 1'b0, 1'b0);
        select = 3'b001; step(); select = 3'b000;
        expect_out("vend0.c1", 6'd0, 3'b001, 1'b0, 1'b0, 1'b1);
        coin_valid = 1'b1; coin_full = 1'b0; step(); coin_valid = 1'b0;
        expect_out("vend0.coin", 6'd0, 3'b001, 1'b0, 1'b1, 1'b1);
        step();
        expect_out("vend0.c3", 6'd0, 3'b001, 1'b0, 1'b0, 1'b1);
        step();
        expect_out("vend0.c4", 6'd0, 3'b001, 1'b0, 1'b0, 1'b1);
        step();
        expect_out("vend0.end", 6'd0, 3'b000, 1'b0, 1'b0, 1'b0);

        // Five 0.5 TL coins; product 0 unaffordable, then {1,2} picks slot 1.
        coins(5, 1'b0);
        expect_out("half5", 6'd5, 3'b000, 1'b0, 1'b0, 1'b0);
        select = 3'b001; step(); select = 3'b000;
        expect_out("short", 6'd5, 3'b000, 1'b0, 1'b0, 1'b0);
        select = 3'b110; step(); select = 3'b000;
        expect_out("vend1.c1", 6'd1, 3'b010, 1'b0, 1'b0, 1'b1);
        repeat (3) step();
        expect_out("vend1.c4", 6'd1, 3'b010, 1'b0, 1'b0, 1'b1);
        step();
`ifdef VENDING_CHANGE_EN
        expect_out("chg1.hi", 6'd1, 3'b000, 1'b1, 1'b0, 1'b1);
        step();
        expect_out("chg1.end", 6'd0, 3'b000, 1'b0, 1'b0, 1'b0);
`else
        expect_out("keep1", 6'd1, 3'b000, 1'b0, 1'b0, 1'b0);
        cancel = 1'b1; step(); cancel = 1'b0;
        expect_out("cancel_ign", 6'd1, 3'b000, 1'b0, 1'b0, 1'b0);
`endif

        // Accepted coin beats simultaneous select and cancel.
        do_reset("rst1");
        coins(1, 1'b1);
        coin_valid = 1'b1; coin_full = 1'b1; select = 3'b100; cancel = 1'b1;
        step();
        coin_valid = 1'b0; coin_full = 1'b0; select = 3'b000; cancel = 1'b0;
        expect_out("prio", 6'd4, 3'b000, 1'b0, 1'b0, 1'b0);

        // Third 1 TL coin, then product 2 (1.5 TL) leaves 3 units.
        coins(1, 1'b1);
        expect_out("coin3", 6'd6, 3'b000, 1'b0, 1'b0, 1'b0);
        select = 3'b100; step(); select = 3'b000;
        expect_out("vend2.c1", 6'd3, 3'b100, 1'b0, 1'b0, 1'b1);
        repeat (3) step();
        expect_out("vend2.c4", 6'd3, 3'b100, 1'b0, 1'b0, 1'b1);
        step();
`ifdef VENDING_CHANGE_EN
        expect_out("chg3.p1", 6'd3, 3'b000, 1'b1, 1'b0, 1'b1);
        step(); expect_out("chg3.l1", 6'd2, 3'b000, 1'b0, 1'b0, 1'b1);
        step(); expect_out("chg3.p2", 6'd2, 3'b000, 1'b1, 1'b0, 1'b1);
        step(); expect_out("chg3.l2", 6'd1, 3'b000, 1'b0, 1'b0, 1'b1);
        step(); expect_out("chg3.p3", 6'd1, 3'b000, 1'b1, 1'b0, 1'b1);
        step(); expect_out("chg3.end", 6'd0, 3'b000, 1'b0, 1'b0, 1'b0);
`else
        expect_out("keep3", 6'd3, 3'b000, 1'b0, 1'b0, 1'b0);
`endif

        // Two 1 TL coins, unaffordable select, then cancel.
        do_reset("rst2");
        coins(2, 1'b1);
        select = 3'b001; step(); select = 3'b000;
        expect_out("short4", 6'd4, 3'b000, 1'b0, 1'b0, 1'b0);
        cancel = 1'b1; step(); cancel = 1'b0;
`ifdef VENDING_CHANGE_EN
        expect_out("ref.p1", 6'd4, 3'b000, 1'b1, 1'b0, 1'b1);
        step(); expect_out("ref.l1", 6'd3, 3'b000, 1'b0, 1'b0, 1'b1);
        step(); expect_out("ref.p2", 6'd3, 3'b000, 1'b1, 1'b0, 1'b1);
        step(); expect_out("ref.l2", 6'd2, 3'b000, 1'b0, 1'b0, 1'b1);
        step(); expect_out("ref.p3", 6'd2, 3'b000, 1'b1, 1'b0, 1'b1);
        step(); expect_out("ref.l3", 6'd1, 3'b000, 1'b0, 1'b0, 1'b1);
        step(); expect_out("ref.p4", 6'd1, 3'b000, 1'b1, 1'b0, 1'b1);
        step(); expect_out("ref.end", 6'd0, 3'b000, 1'b0, 1'b0, 1'b0);
`else
        expect_out("cancel4", 6'd4, 3'b000, 1'b0, 1'b0, 1'b0);
`endif

        // Fill to 63, reject coins that would overflow, then reset mid-vend.
        do_reset("rst3");
        coins(31, 1'b1);
        expect_out("fill62", 6'd62, 3'b000, 1'b0, 1'b0, 1'b0);
        coins(1, 1'b0);
        expect_out("fill63", 6'd63, 3'b000, 1'b0, 1'b0, 1'b0);
        coins(1, 1'b1);
        expect_out("ovf_full", 6'd63, 3'b000, 1'b0, 1'b1, 1'b0);
        coins(1, 1'b0);
        expect_out("ovf_half", 6'd63, 3'b000, 1'b0, 1'b1, 1'b0);
        step();
        expect_out("ovf_clr", 6'd63, 3'b000, 1'b0, 1'b0, 1'b0);
        select = 3'b001; step(); select = 3'b000;
        expect_out("vend63", 6'd53, 3'b001, 1'b0, 1'b0, 1'b1);
        step();
        reset = 1'b1; step(); reset = 1'b0;
        expect_out("rst_vend", 6'd0, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("post_rst", 6'd0, 3'b000, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vending_multi.md
VENDING_MULTI -- requirements
Module: vending_multi

Interface
REQ-001 SHALL have parameter NUM_PRODUCTS, default 3: number of product slots and motors.
REQ-002 SHALL have parameter CREDIT_W, default 6: credit register width, in units of 0.5 TL.
REQ-003 SHALL have parameter PRICES, default {10,4,3} (5 TL, 2 TL, 1.5 TL): packed NUM_PRODUCTS x CREDIT_W prices in 0.5 TL units; index 0 is the lowest field.
REQ-004 SHALL have parameter MOTOR_CYCLES, default 4: product motor on-time in cycles.
REQ-005 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: one clock; reset is synchronous and active-high.
REQ-007 SHALL have port coin_valid, input, 1: coin sensor; each high cycle is one coin.
REQ-008 SHALL have port coin_full, input, 1: denomination, 1 = 1 TL (2 units), 0 = 0.5 TL (1 unit); sampled with coin_valid.
REQ-009 SHALL have port cancel, input, 1: refund request.
REQ-010 SHALL have port select, input, NUM_PRODUCTS: product request, one bit per slot.
REQ-011 SHALL have port motor, output, NUM_PRODUCTS: dispensing motor per slot.
REQ-012 SHALL have port change_motor, output, 1: one high cycle per 0.5 TL returned.
REQ-013 SHALL have port coin_reject, output, 1: one-cycle pulse, the coin in the previous cycle was not credited.
REQ-014 SHALL have ports credit (output, CREDIT_W, current credit) and busy (output, 1, high in VEND or CHANGE).

Function
REQ-015 SHALL implement states IDLE (credit 0), COLLECT (credit > 0), VEND and CHANGE.
REQ-016 In IDLE/COLLECT, an accepted coin SHALL add 1 or 2 to credit on the next edge; IDLE -> COLLECT.
REQ-017 A coin that would overflow 2^CREDIT_W-1, or that arrives in VEND/CHANGE, SHALL be dropped, with coin_reject high the next cycle.
REQ-018 In a cycle with an accepted coin, select and cancel SHALL be ignored; the coin has priority.
REQ-019 With multiple select bits high, the lowest index SHALL win.
REQ-020 Select i with credit >= PRICES[i] SHALL enter VEND: credit -= PRICES[i], and motor[i] rises on the next edge (latency 1).
REQ-021 Select i with credit < PRICES[i] SHALL be ignored, with no state change.
REQ-022 In VEND, motor[i] SHALL stay high exactly MOTOR_CYCLES cycles; the other motors stay low.
REQ-023 On VEND exit, if REQ-033 applies and credit > 0, the block SHALL go to CHANGE; otherwise to COLLECT if credit > 0, else IDLE.
REQ-024 In CHANGE, change_motor SHALL alternate high 1 cycle / low 1 cycle; each high cycle decrements credit by 1; at credit 0 -> IDLE.
REQ-025 Product prices of 0 SHALL be legal: vend with no credit change.
REQ-026 motor SHALL be one-hot or zero at all times; motor and change_motor SHALL never be high together.

Reset
REQ-027 Reset SHALL force IDLE, credit 0, and all motors, change_motor, coin_reject and busy to 0 on the next edge.
REQ-028 Reset mid-VEND or mid-CHANGE SHALL abort immediately, and the remaining credit is lost.
REQ-029 Reset SHALL dominate coin_valid, select and cancel in the same cycle.

Configuration
REQ-030 Macro VENDING_CHANGE_EN SHALL select the change feature.
REQ-031 With VENDING_CHANGE_EN defined, change SHALL be returned after a vend (REQ-023).
REQ-032 With VENDING_CHANGE_EN defined, cancel in COLLECT SHALL enter CHANGE and refund all credit.
REQ-033 Without VENDING_CHANGE_EN: change_motor is tied 0, cancel is ignored, CHANGE is unreachable, and leftover credit is retained in COLLECT.

Structure
REQ-034 Package vending_pkg SHALL hold the state enum, denomination unit constants (HALF=1, FULL=2) and the default price vector.
REQ-035 Sub-module vending_motor_timer (load value, count down, done pulse) SHALL time the VEND and CHANGE phases.

Verification (defaults, VENDING_CHANGE_EN defined)
REQ-036 Five 1 TL coins then select[0] -> credit 10, motor[0] high 4 cycles, no change_motor, IDLE.
REQ-037 Five 1 TL coins, one 0.5 TL coin, then select[0] -> motor[0] for 4 cycles, then one change_motor pulse, credit 0.
REQ-038 Five 0.5 TL coins then select[1] -> motor[1] for 4 cycles, then one change_motor pulse.
REQ-039 Two 1 TL coins then select[0] -> ignored, credit stays 4; cancel -> 4 change_motor pulses, IDLE.
REQ-040 Coin during VEND, and coin at credit 63 -> coin_reject pulse, credit unchanged; reset mid-VEND -> all outputs 0 next cycle.
REQ-041 Without the macro, three 1 TL coins then select[2] -> motor[2] for 4 cycles, credit 3 retained, change_motor never high.
